// File: rtl/arm_cpu_pkg.sv
// arm_cpu_pkg: shared types and constants for the ARM datapath memory stage
package arm_cpu_pkg;
   localparam int WORD_BYTES = 8;
   localparam int DATA_WIDTH = 64;
   localparam int OFFSET_BITS = $clog2(WORD_BYTES);
   localparam int INDEX_BITS = DATA_WIDTH - OFFSET_BITS;
   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} mem_state_t;
   // word-aligned and inside the array; the full index is compared so high address bits can never wrap
   function automatic logic addr_legal(input logic [DATA_WIDTH-1:0] address, input int depth_words);
      return (address[OFFSET_BITS-1:0] == '0) &&
             (address[DATA_WIDTH-1:OFFSET_BITS] < INDEX_BITS'($unsigned(depth_words)));
   endfunction
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: request/response bus between the ALU-side control and the data memory
interface data_memory_if;
   import arm_cpu_pkg::*;
   logic [DATA_WIDTH-1:0] input_address;
   logic [DATA_WIDTH-1:0] input_write_data;
   logic                  input_mem_read;
   logic                  input_mem_write;
   logic [DATA_WIDTH-1:0] output_read_data;
   logic                  output_valid;
   logic                  output_busy;
   logic                  output_error;
   modport master (
      output input_address, input_write_data, input_mem_read, input_mem_write,
      input  output_read_data, output_valid, output_busy, output_error
   );
   modport slave (
      input  input_address, input_write_data, input_mem_read, input_mem_write,
      output output_read_data, output_valid, output_busy, output_error
   );
endinterface

// File: rtl/data_memory_array.sv
// data_memory_array: flop word array with reset clear, one write port and a registered read port
module data_memory_array
   import arm_cpu_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int AW = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_enable,
   input  logic                  read_enable,
   input  logic [AW-1:0]         index,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] read_data
);
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   // reset wipes every word; otherwise write and read the selected word
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
         read_data <= '0;
      end else begin
         if (write_enable) mem[index] <= write_data;
         if (read_enable) read_data <= mem[index];
      end
   end
endmodule

// File: rtl/data_memory.sv
// data_memory: word-addressed data memory with a three-state request controller
module data_memory
   import arm_cpu_pkg::*;
#(
   parameter int DEPTH_WORDS = 128
) (
   input  logic         input_clock,
   input  logic         input_reset,
   data_memory_if.slave bus
);
   localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   mem_state_t            state, state_next;
   logic [AW-1:0]         index;
   logic                  is_write;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  error;
   logic                  request, reject, accept;
   assign request = bus.input_mem_read | bus.input_mem_write;
   assign reject  = (bus.input_mem_read & bus.input_mem_write) | !addr_legal(bus.input_address, DEPTH_WORDS);
   assign accept  = (state == IDLE) & request & !reject;
   // IDLE waits for a clean request, ACCESS touches the array, RESPOND signals completion
   always_comb begin
      state_next = state;
      state_next = state == IDLE   ? (accept ? ACCESS : IDLE) :
                   state == ACCESS ? RESPOND : IDLE;
   end
   // controller state, request latches and the one-cycle reject pulse
   always_ff @(posedge input_clock) begin
      if (input_reset) begin
         state      <= IDLE;
         index      <= '0;
         is_write   <= 1'b0;
         write_data <= '0;
         error      <= 1'b0;
      end else begin
         state <= state_next;
         error <= (state == IDLE) & request & reject;
         if (accept) begin
            index      <= bus.input_address[AW+OFFSET_BITS-1:OFFSET_BITS];
            is_write   <= bus.input_mem_write;
            write_data <= bus.input_write_data;
         end
      end
   end
   data_memory_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
      .clk          (input_clock),
      .rst          (input_reset),
      .write_enable (state == ACCESS && is_write),
      .read_enable  (state == ACCESS && !is_write),
      .index        (index),
      .write_data   (write_data),
      .read_data    (bus.output_read_data)
   );
   assign bus.output_valid = state == RESPOND;
   assign bus.output_busy  = state != IDLE;
   assign bus.output_error = error;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed scoreboard bench for data_memory
module tb_data_memory;
   import arm_cpu_pkg::*;
   typedef struct {logic err; logic [63:0] data;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0, fails = 0, valid_cnt = 0, err_cnt = 0;
   exp_t sb[$];
   logic [63:0] mem_m [128];
   logic [63:0] model_rd = '0;
   always #5 clk = ~clk;
   data_memory_if bus ();
   data_memory #(.DEPTH_WORDS(128)) dut (.input_clock(clk), .input_reset(rst), .bus(bus));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.output_busy === 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_idle", {63'd0, bus.output_busy}, 64'd0);
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] data);
      logic bad;
      @(negedge clk);
      bus.input_mem_read   = rd;
      bus.input_mem_write  = wr;
      bus.input_address    = addr;
      bus.input_write_data = data;
      bad = (rd & wr) || addr[2:0] != 3'd0 || addr[63:3] >= 61'd128;
      if (bad) sb.push_back('{1'b1, model_rd});
      else if (rd) begin
         model_rd = mem_m[addr[9:3]];
         sb.push_back('{1'b0, model_rd});
      end else begin
         mem_m[addr[9:3]] = data;
         sb.push_back('{1'b0, model_rd});
      end
      @(posedge clk); #1;
      bus.input_mem_read  = 1'b0;
      bus.input_mem_write = 1'b0;
      if (bad) chk("reject_not_busy", {63'd0, bus.output_busy}, 64'd0);
      else wait_idle();
   endtask

   // every response pulse is matched in order against the scoreboard
   always @(posedge clk) begin
      #1;
      if (bus.output_valid) valid_cnt++;
      if (bus.output_error) err_cnt++;
      if (bus.output_valid || bus.output_error) begin
         checks++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_response: observed valid=%b error=%b, required no response", bus.output_valid, bus.output_error);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_is_error", {63'd0, bus.output_error}, {63'd0, e.err});
            chk("resp_read_data", bus.output_read_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int v0, e0;
      for (int i = 0; i < 128; i++) mem_m[i] = '0;
      bus.input_mem_read = 1'b0;
      bus.input_mem_write = 1'b0;
      bus.input_address = '0;
      bus.input_write_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", {63'd0, bus.output_busy}, 64'd0);
      chk("reset_valid", {63'd0, bus.output_valid}, 64'd0);
      chk("reset_error", {63'd0, bus.output_error}, 64'd0);
      chk("reset_read_data", bus.output_read_data, 64'd0);
      rst = 1'b0;
      // first read with cycle-exact timing checks
      @(negedge clk);
      bus.input_mem_read = 1'b1;
      bus.input_address = 64'h0;
      sb.push_back('{1'b0, 64'd0});
      @(posedge clk); #1;
      bus.input_mem_read = 1'b0;
      chk("t1_busy_n1", {63'd0, bus.output_busy}, 64'd1);
      chk("t1_valid_n1", {63'd0, bus.output_valid}, 64'd0);
      @(posedge clk); #1;
      chk("t1_busy_n2", {63'd0, bus.output_busy}, 64'd1);
      chk("t1_valid_n2", {63'd0, bus.output_valid}, 64'd1);
      chk("t1_data_n2", bus.output_read_data, 64'd0);
      @(posedge clk); #1;
      chk("t1_busy_n3", {63'd0, bus.output_busy}, 64'd0);
      chk("t1_valid_n3", {63'd0, bus.output_valid}, 64'd0);
      // write then read back, neighbours untouched
      issue(1'b0, 1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D);
      issue(1'b1, 1'b0, 64'h18, 64'h0);
      issue(1'b1, 1'b0, 64'h10, 64'h0);
      issue(1'b1, 1'b0, 64'h20, 64'h0);
      issue(1'b1, 1'b0, 64'h18, 64'h0);
      // back-to-back rejected requests
      v0 = valid_cnt;
      e0 = err_cnt;
      issue(1'b1, 1'b0, 64'h1C, 64'h0);
      issue(1'b1, 1'b0, 64'h400, 64'h0);
      issue(1'b1, 1'b1, 64'h8, 64'h0);
      issue(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hAB);
      issue(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h77);
      issue(1'b0, 1'b1, 64'h0000_0000_0000_0400, 64'h99);
      @(posedge clk); #1;
      chk("err_count", 64'(err_cnt - e0), 64'd6);
      chk("err_no_valid", 64'(valid_cnt - v0), 64'd0);
      chk("err_data_held", bus.output_read_data, 64'hDEADBEEF_CAFEF00D);
      issue(1'b1, 1'b0, 64'h0, 64'h0);
      issue(1'b1, 1'b0, 64'h8, 64'h0);
      issue(1'b1, 1'b0, 64'h18, 64'h0);
      // last legal word
      e0 = err_cnt;
      issue(1'b0, 1'b1, 64'h3F8, 64'h1234);
      issue(1'b1, 1'b0, 64'h3F8, 64'h0);
      chk("last_word_no_error", 64'(err_cnt - e0), 64'd0);
      // held request while busy: accepted only at N and N+3
      issue(1'b0, 1'b1, 64'h8, 64'h55AA);
      v0 = valid_cnt;
      e0 = err_cnt;
      @(negedge clk);
      bus.input_mem_read = 1'b1;
      bus.input_address = 64'h8;
      model_rd = mem_m[1];
      sb.push_back('{1'b0, model_rd});
      sb.push_back('{1'b0, model_rd});
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            bus.input_mem_write = 1'b1;
            bus.input_address = 64'h1C;
            bus.input_write_data = 64'hBAD;
         end
         if (c == 2) begin
            bus.input_mem_write = 1'b0;
            bus.input_address = 64'h8;
         end
         if (c == 5) bus.input_mem_read = 1'b0;
      end
      wait_idle();
      @(posedge clk); #1;
      chk("hold_two_reads", 64'(valid_cnt - v0), 64'd2);
      chk("hold_no_error", 64'(err_cnt - e0), 64'd0);
      issue(1'b1, 1'b0, 64'h18, 64'h0);
      // reset during the ACCESS cycle of a write
      v0 = valid_cnt;
      @(negedge clk);
      bus.input_mem_write = 1'b1;
      bus.input_address = 64'h0;
      bus.input_write_data = 64'hFF;
      @(posedge clk); #1;
      bus.input_mem_write = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 128; i++) mem_m[i] = '0;
      model_rd = '0;
      chk("abort_busy", {63'd0, bus.output_busy}, 64'd0);
      chk("abort_read_data", bus.output_read_data, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_valid", 64'(valid_cnt - v0), 64'd0);
      issue(1'b1, 1'b0, 64'h0, 64'h0);
      issue(1'b1, 1'b0, 64'h3F8, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
